// File: rtl/cpu_pkg.sv
// Shared types and default widths for the multicycle CPU controller and its ALU.
package cpu_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 3;
  localparam int PC_W    = 6;
  localparam int INSTR_W = 3 + 3 * ADDR_W;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_JZ   = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  typedef struct packed {
    opcode_t           op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } instr_t;

  function automatic logic writes_reg(opcode_t op);
    return (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; arithmetic wraps modulo 2^DATA_W, carry and borrow are dropped.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  opcode_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_LDI:  y_o = imm_i;
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute/writeback sequencer driving register_file, with a 4-bit ALU and zero flag.
//  state     | meaning
//  IDLE      | waiting for run
//  FETCH     | ir <= ROM word at pc
//  DECODE    | latch register operands A, B
//  EXECUTE   | ALU result, flag update, branch/halt resolution
//  WRITEBACK | result written to rd, pc advances
//  HALTED    | absorbing until reset
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int PC_W   = cpu_pkg::PC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [PC_W-1:0]       instr_addr,
  input  logic [3+3*ADDR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]     read_address1,
  output logic [ADDR_W-1:0]     read_address2,
  input  logic [DATA_W-1:0]     read_data1,
  input  logic [DATA_W-1:0]     read_data2,
  output logic [ADDR_W-1:0]     write_address,
  output logic [DATA_W-1:0]     write_data,
  output logic                  write_enable,
  output logic                  zero,
  output logic                  halted
);

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  instr_t                ir_q, ir_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  zero_q, zero_d;

  logic [INSTR_W-1:0]    ir_bits;
  logic [DATA_W-1:0]     alu_y;
  logic [PC_W-1:0]       pc_inc;
  state_t                after_instr;

  assign ir_bits     = ir_q;
  assign pc_inc      = pc_q + PC_W'(1);
  assign after_instr = run ? S_FETCH : S_IDLE;

  alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (ir_q.op),
    .a_i   (a_q),
    .b_i   (b_q),
    .imm_i (ir_bits[DATA_W-1:0]),
    .y_o   (alu_y)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instr_t'(instr_data);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = read_data1;
        b_d     = read_data2;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        result_d = alu_y;
        if (writes_reg(ir_q.op)) begin
          zero_d  = (alu_y == '0);
          state_d = S_WRITEBACK;
        end else if (ir_q.op == OP_HALT) begin
          state_d = S_HALTED;
        end else if (ir_q.op == OP_JZ) begin
          pc_d    = zero_q ? ir_bits[PC_W-1:0] : pc_inc;
          state_d = after_instr;
        end else begin
          pc_d    = pc_inc;
          state_d = after_instr;
        end
      end
      S_WRITEBACK: begin
        pc_d    = pc_inc;
        state_d = after_instr;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // A reset arriving during WRITEBACK must not let the register file capture the write.
  assign write_enable  = (state_q == S_WRITEBACK) && reset;
  assign instr_addr    = pc_q;
  assign read_address1 = ir_q.rs1;
  assign read_address2 = ir_q.rs2;
  assign write_address = ir_q.rd;
  assign write_data    = result_q;
  assign zero          = zero_q;
  assign halted        = (state_q == S_HALTED);

endmodule
